fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage and IF/ID pipeline register for the WISC-S15 16-bit CPU.
- Holds the PC and issues word-addressed requests to instruction memory over a req/rdy handshake.
- Buffers one response when decode is stalled.
- Presents the fetched instruction to the control decoder.
- Flushes on branch/call/return redirects and stops fetching when a HALT word (16'hFFFF) enters IF/ID.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold IF/ID contents
redirect_valid  input  1  taken branch/call/return; flush and load PC
redirect_pc  input  16  redirect target (word address)
imem_req  output  1  instruction memory request
imem_addr  output  16  request address; stable while imem_req=1 and imem_rdy=0
imem_rdy  input  1  request completes this cycle; imem_data valid
imem_data  input  16  instruction word
instr_out  output  16  IF/ID instruction to control decoder
pc_plus1_out  output  16  IF/ID fetched address + 1 (call return address, branch base)
instr_valid  output  1  instr_out is a real fetched instruction
halted  output  1  fetch stopped on HALT

Behaviour:
- Reset values: pc=RESET_PC, state=S_FETCH, instr_out=NOP_INSTR (16'hF000), pc_plus1_out=0, instr_valid=0, halted=0, hold_valid=0, imem_req=0 during the reset cycle.
- NOP_INSTR uses opcode 1111 and is not all-ones, so the decoder writes nothing and does not halt.
- Priority: rst > redirect_valid > stall > normal fetch.
- States are S_FETCH, S_DROP and S_HALT.
- S_FETCH request issue:
  - imem_req rises only when stall=0 and hold_valid=0, with imem_addr=pc.
  - Once raised, imem_req stays high with a stable address until imem_rdy=1, regardless of stall.
- S_FETCH response, stall=0: on imem_rdy, IF/ID <= {imem_data, pc+1}, instr_valid=1, pc <= pc+1.
  - With imem_rdy held at 1, throughput is 1 instruction per cycle.
  - Latency is 1 cycle from request to instr_out.
- S_FETCH response, stall=1:
  - IF/ID holds its contents.
  - A response arriving this cycle goes to the hold register (hold_valid=1) and pc increments.
  - No new request is made while hold_valid=1.
- Hold release: in the first cycle with stall=0 and hold_valid=1, IF/ID <= hold contents and hold_valid clears. imem_req may rise in the same cycle.
- Stall with no response: if stall=0 and no response arrives, IF/ID loads NOP_INSTR with instr_valid=0 (bubble).
- Redirect:
  - IF/ID <= NOP_INSTR, instr_valid=0, hold_valid=0, pc <= redirect_pc.
  - If a request is outstanding and imem_rdy=0, go to S_DROP. Otherwise stay in S_FETCH; a same-cycle response is discarded.
  - Redirect overrides stall.
- S_DROP:
  - Keep imem_req=1 at the old address until imem_rdy.
  - Discard the returned data and go to S_FETCH.
  - A further redirect in S_DROP updates pc only.
- HALT entry: when 16'hFFFF is loaded into IF/ID (directly or from hold), state moves to S_HALT next edge.
- S_HALT:
  - halted=1 and imem_req=0.
  - IF/ID keeps the HALT word so the decoder asserts HALT.
  - A redirect in S_HALT (older control transfer squashing the HALT) flushes IF/ID, loads pc, clears halted and goes to S_FETCH.
- PC arithmetic: pc+1 is 16-bit modulo, so 16'hFFFF wraps to 16'h0000; pc_plus1_out wraps the same way.
- Reset mid-request: rst abandons any outstanding request; the memory model must tolerate req dropping.

Decomposition:
- Shared package wisc_pkg holds:
  - NOP_INSTR and HALT_INSTR constants;
  - WORD_W=16;
  - the fetch_state_t enum {S_FETCH, S_DROP, S_HALT}.
- Flat module; no sub-module warranted. The hold register is an always_ff block inside fetch_stage.

Test Plan:
- Reset, imem_rdy tied 1, memory returns addr-based words -> instr_out 0x0000..0x0003 on consecutive cycles with instr_valid=1 and pc_plus1_out=1..4.
- imem_rdy delayed 3 cycles -> imem_addr stable for 4 cycles; IF/ID shows NOP_INSTR with instr_valid=0 until data arrives.
- stall=1 for 3 cycles while a response lands -> IF/ID unchanged, hold_valid=1, no new request; after stall drops, the held word appears the next cycle.
- Redirect to 0x0040 while a request is outstanding (rdy low) -> S_DROP, late data discarded, next request addr=0x0040, IF/ID=NOP_INSTR.
- Memory returns 16'hFFFF at 0x0005 -> halted=1 next cycle, imem_req stays 0; then redirect_valid to 0x0010 -> halted=0 and fetch resumes at 0x0010.
- RESET_PC=16'hFFFF, imem_rdy=1 -> fetch addr 0xFFFF then 0x0000; pc_plus1_out=0x0000 for the first instruction.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC-S15 definitions: word width, special instruction encodings
// and the fetch-stage state encoding.
package wisc_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR  = 16'hF000;
  localparam logic [WORD_W-1:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DROP,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// WISC-S15 instruction fetch stage with IF/ID register, one-entry stall
// buffer, redirect flush and HALT detection.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_plus1_out,
  output logic              instr_valid,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              hold_valid_q, hold_valid_d;
  logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_W-1:0] hold_pc1_q, hold_pc1_d;
  logic [WORD_W-1:0] pc_inc;
  logic              resp;

  // req_q marks a request still waiting for imem_rdy; its address is frozen in addr_q.
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      S_FETCH: imem_req = req_q | (!stall && !hold_valid_q && !redirect_valid);
      S_DROP:  imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
    if (rst) imem_req = 1'b0;
    imem_addr = req_q ? addr_q : pc_q;
    resp      = imem_req && imem_rdy;
    pc_inc    = pc_q + 16'd1;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc1_d        = pc1_q;
    valid_d      = valid_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc1_d   = hold_pc1_q;
    req_d        = imem_req && !imem_rdy;
    addr_d       = imem_addr;

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      hold_valid_d = 1'b0;
      state_d      = (imem_req && !imem_rdy) ? S_DROP : S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (!stall) begin
            if (hold_valid_q) begin
              instr_d      = hold_instr_q;
              pc1_d        = hold_pc1_q;
              valid_d      = 1'b1;
              hold_valid_d = 1'b0;
              if (hold_instr_q == HALT_INSTR) state_d = S_HALT;
            end else if (resp) begin
              instr_d = imem_data;
              pc1_d   = pc_inc;
              valid_d = 1'b1;
              pc_d    = pc_inc;
              if (imem_data == HALT_INSTR) state_d = S_HALT;
            end else begin
              instr_d = NOP_INSTR;
              valid_d = 1'b0;
            end
          end else if (resp) begin
            hold_instr_d = imem_data;
            hold_pc1_d   = pc_inc;
            hold_valid_d = 1'b1;
            pc_d         = pc_inc;
          end
        end
        S_DROP: begin
          if (imem_rdy) state_d = S_FETCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Single-entry buffer for a response that lands while decode is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc1_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc1_q   <= hold_pc1_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus1_out = pc1_q;
  assign instr_valid  = valid_q;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main sequence plus a
// separate instance started at PC 16'hFFFF to cover wrap-around.
module tb_fetch_stage;

  typedef struct {
    logic        st;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        cpc;
    logic        valid;
    logic        halted;
  } vec_t;

  logic        clk;
  logic        rst, stall, redirect_valid, imem_rdy;
  logic [15:0] redirect_pc;
  logic        imem_req, instr_valid, halted;
  logic [15:0] imem_addr, imem_data, instr_out, pc_plus1_out;

  logic        rst1, stall1, rv1, rdy1;
  logic [15:0] rpc1;
  logic        req1, valid1, halted1;
  logic [15:0] addr1, data1, instr1, pc1_1;

  int checks = 0;
  int errors = 0;
  vec_t tbl[28];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0005) return 16'hFFFF;
    if (a == 16'hFFFF) return 16'h1234;
    return a;
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign data1     = mem_word(addr1);

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .instr_out(instr_out),
    .pc_plus1_out(pc_plus1_out), .instr_valid(instr_valid), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst1), .stall(stall1), .redirect_valid(rv1),
    .redirect_pc(rpc1), .imem_req(req1), .imem_addr(addr1),
    .imem_rdy(rdy1), .imem_data(data1), .instr_out(instr1),
    .pc_plus1_out(pc1_1), .instr_valid(valid1), .halted(halted1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic rv, input logic [15:0] rpc,
                              input logic rdy, input logic req, input logic [15:0] addr,
                              input logic [15:0] instr, input logic [15:0] pc1,
                              input logic cpc, input logic valid, input logic halted);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.req = req; v.addr = addr;
    v.instr = instr; v.pc1 = pc1; v.cpc = cpc; v.valid = valid; v.halted = halted;
    return v;
  endfunction

  initial begin
    // back-to-back fetch, rdy tied high
    tbl[0]  = mk(0, 0, 16'h0, 1, 1, 16'h0000, 16'h0000, 16'h0001, 1, 1, 0);
    tbl[1]  = mk(0, 0, 16'h0, 1, 1, 16'h0001, 16'h0001, 16'h0002, 1, 1, 0);
    tbl[2]  = mk(0, 0, 16'h0, 1, 1, 16'h0002, 16'h0002, 16'h0003, 1, 1, 0);
    tbl[3]  = mk(0, 0, 16'h0, 1, 1, 16'h0003, 16'h0003, 16'h0004, 1, 1, 0);
    // rdy delayed three cycles
    tbl[4]  = mk(0, 0, 16'h0, 0, 1, 16'h0004, 16'hF000, 16'h0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 16'h0, 0, 1, 16'h0004, 16'hF000, 16'h0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 16'h0, 0, 1, 16'h0004, 16'hF000, 16'h0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 16'h0, 1, 1, 16'h0004, 16'h0004, 16'h0005, 1, 1, 0);
    // HALT word at 0x0005, then redirect out of halt
    tbl[8]  = mk(0, 0, 16'h0, 1, 1, 16'h0005, 16'hFFFF, 16'h0006, 1, 1, 1);
    tbl[9]  = mk(0, 0, 16'h0, 1, 0, 16'h0, 16'hFFFF, 16'h0006, 1, 1, 1);
    tbl[10] = mk(0, 0, 16'h0, 1, 0, 16'h0, 16'hFFFF, 16'h0006, 1, 1, 1);
    tbl[11] = mk(0, 1, 16'h0010, 1, 0, 16'h0, 16'hF000, 16'h0, 0, 0, 0);
    tbl[12] = mk(0, 0, 16'h0, 1, 1, 16'h0010, 16'h0010, 16'h0011, 1, 1, 0);
    // redirect with request outstanding -> drop, second redirect while dropping
    tbl[13] = mk(0, 0, 16'h0, 0, 1, 16'h0011, 16'hF000, 16'h0, 0, 0, 0);
    tbl[14] = mk(0, 1, 16'h0040, 0, 1, 16'h0011, 16'hF000, 16'h0, 0, 0, 0);
    tbl[15] = mk(0, 1, 16'h0050, 0, 1, 16'h0011, 16'hF000, 16'h0, 0, 0, 0);
    tbl[16] = mk(0, 0, 16'h0, 1, 1, 16'h0011, 16'hF000, 16'h0, 0, 0, 0);
    tbl[17] = mk(0, 0, 16'h0, 1, 1, 16'h0050, 16'h0050, 16'h0051, 1, 1, 0);
    // redirect overriding stall, same-cycle response discarded
    tbl[18] = mk(0, 0, 16'h0, 0, 1, 16'h0051, 16'hF000, 16'h0, 0, 0, 0);
    tbl[19] = mk(1, 1, 16'h0080, 1, 1, 16'h0051, 16'hF000, 16'h0, 0, 0, 0);
    tbl[20] = mk(0, 0, 16'h0, 1, 1, 16'h0080, 16'h0080, 16'h0081, 1, 1, 0);
    // stall: no new request, response parked in hold, released after stall
    tbl[21] = mk(1, 0, 16'h0, 1, 0, 16'h0, 16'h0080, 16'h0081, 1, 1, 0);
    tbl[22] = mk(0, 0, 16'h0, 0, 1, 16'h0081, 16'hF000, 16'h0, 0, 0, 0);
    tbl[23] = mk(1, 0, 16'h0, 1, 1, 16'h0081, 16'hF000, 16'h0, 0, 0, 0);
    tbl[24] = mk(1, 0, 16'h0, 1, 0, 16'h0, 16'hF000, 16'h0, 0, 0, 0);
    tbl[25] = mk(1, 0, 16'h0, 1, 0, 16'h0, 16'hF000, 16'h0, 0, 0, 0);
    tbl[26] = mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0081, 16'h0082, 1, 1, 0);
    tbl[27] = mk(0, 0, 16'h0, 1, 1, 16'h0082, 16'h0082, 16'h0083, 1, 1, 0);

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; imem_rdy = 1'b0;
    rst1 = 1'b1; stall1 = 1'b0; rv1 = 1'b0; rpc1 = 16'h0; rdy1 = 1'b1;

    @(posedge clk); #1;
    #2;
    chk("reset_req", {15'd0, imem_req}, 16'd0);
    @(posedge clk); #1;
    chk("reset_instr", instr_out, 16'hF000);
    chk("reset_pc1", pc_plus1_out, 16'h0000);
    chk("reset_valid", {15'd0, instr_valid}, 16'd0);
    chk("reset_halted", {15'd0, halted}, 16'd0);
    $display("reset: instr=%h pc1=%h valid=%b halted=%b", instr_out, pc_plus1_out, instr_valid, halted);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      stall = tbl[i].st; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc; imem_rdy = tbl[i].rdy;
      #2;
      chk($sformatf("v%0d_req", i), {15'd0, imem_req}, {15'd0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_instr", i), instr_out, tbl[i].instr);
      chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, tbl[i].valid});
      chk($sformatf("v%0d_halted", i), {15'd0, halted}, {15'd0, tbl[i].halted});
      if (tbl[i].cpc) chk($sformatf("v%0d_pc1", i), pc_plus1_out, tbl[i].pc1);
      $display("vec %0d: st=%b rv=%b rdy=%b -> instr=%h pc1=%h valid=%b halted=%b",
               i, tbl[i].st, tbl[i].rv, tbl[i].rdy, instr_out, pc_plus1_out, instr_valid, halted);
    end
    stall = 1'b0; redirect_valid = 1'b0; imem_rdy = 1'b0;

    // RESET_PC = 0xFFFF instance: first fetch at 0xFFFF, then wrap to 0x0000
    #2;
    chk("wrap_reset_req", {15'd0, req1}, 16'd0);
    @(posedge clk); #1;
    chk("wrap_reset_pc1", pc1_1, 16'h0000);
    rst1 = 1'b0;
    #2;
    chk("wrap_req0", {15'd0, req1}, 16'd1);
    chk("wrap_addr0", addr1, 16'hFFFF);
    @(posedge clk); #1;
    chk("wrap_instr0", instr1, 16'h1234);
    chk("wrap_pc1_0", pc1_1, 16'h0000);
    chk("wrap_valid0", {15'd0, valid1}, 16'd1);
    $display("wrap txn 0: instr=%h pc1=%h", instr1, pc1_1);
    #2;
    chk("wrap_addr1", addr1, 16'h0000);
    @(posedge clk); #1;
    chk("wrap_instr1", instr1, 16'h0000);
    chk("wrap_pc1_1", pc1_1, 16'h0001);
    $display("wrap txn 1: instr=%h pc1=%h", instr1, pc1_1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
